// File: rtl/osc_trigger_capture.sv
// Trigger/capture controller between the ADC sample stream and the sample FIFO.
// Detects a level crossing (or auto timeout) and writes post_len samples to the FIFO.
module osc_trigger_capture #(
    parameter int CNT_W  = 16,
    parameter int DATA_W = 8
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic              arm,
    input  logic              abort,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] adc_data,
    input  logic [DATA_W-1:0] trig_level,
    input  logic              trig_falling,
    input  logic              auto_en,
    input  logic [CNT_W-1:0]  timeout,
    input  logic [CNT_W-1:0]  post_len,
    input  logic              fifo_full,
    output logic              fifo_wr,
    output logic [DATA_W-1:0] fifo_data,
    output logic              busy,
    output logic              triggered,
    output logic              auto_fired,
    output logic              overflow,
    output logic              done,
    output logic [CNT_W-1:0]  cap_cnt
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ARMED   = 2'd1;
    localparam logic [1:0] S_CAPTURE = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] level_q, level_d;
    logic              falling_q, falling_d;
    logic              auto_q, auto_d;
    logic [CNT_W-1:0]  timeout_q, timeout_d;
    logic [CNT_W-1:0]  post_len_q, post_len_d;
    logic [DATA_W-1:0] prev_q, prev_d;
    logic              prev_valid_q, prev_valid_d;
    logic [CNT_W-1:0]  tmo_cnt_q, tmo_cnt_d;
    logic [CNT_W-1:0]  cap_cnt_q, cap_cnt_d;
    logic              triggered_q, triggered_d;
    logic              auto_fired_q, auto_fired_d;
    logic              overflow_q, overflow_d;
    logic              fifo_wr_q, fifo_wr_d;
    logic [DATA_W-1:0] fifo_data_q, fifo_data_d;

    logic              edge_hit;
    logic              auto_hit;
    logic              take_sample;
    logic [CNT_W-1:0]  cap_cnt_inc;

    always_comb begin
        if (falling_q) begin
            edge_hit = prev_valid_q && (prev_q > level_q) && (adc_data <= level_q);
        end else begin
            edge_hit = prev_valid_q && (prev_q < level_q) && (adc_data >= level_q);
        end
        // A zero timeout means "fire on the first valid sample".
        auto_hit    = auto_q && ((timeout_q == CNT_ZERO) || (tmo_cnt_q == timeout_q - CNT_ONE));
        cap_cnt_inc = cap_cnt_q + CNT_ONE;
    end

    always_comb begin
        state_d      = state_q;
        level_d      = level_q;
        falling_d    = falling_q;
        auto_d       = auto_q;
        timeout_d    = timeout_q;
        post_len_d   = post_len_q;
        prev_d       = prev_q;
        prev_valid_d = prev_valid_q;
        tmo_cnt_d    = tmo_cnt_q;
        cap_cnt_d    = cap_cnt_q;
        triggered_d  = triggered_q;
        auto_fired_d = auto_fired_q;
        overflow_d   = overflow_q;
        fifo_wr_d    = 1'b0;
        fifo_data_d  = fifo_data_q;
        take_sample  = 1'b0;

        if (abort) begin
            state_d      = S_IDLE;
            cap_cnt_d    = CNT_ZERO;
            tmo_cnt_d    = CNT_ZERO;
            prev_valid_d = 1'b0;
            triggered_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (arm) begin
                        level_d      = trig_level;
                        falling_d    = trig_falling;
                        auto_d       = auto_en;
                        timeout_d    = timeout;
                        post_len_d   = (post_len == CNT_ZERO) ? CNT_ONE : post_len;
                        cap_cnt_d    = CNT_ZERO;
                        tmo_cnt_d    = CNT_ZERO;
                        prev_valid_d = 1'b0;
                        triggered_d  = 1'b0;
                        auto_fired_d = 1'b0;
                        overflow_d   = 1'b0;
                        state_d      = S_ARMED;
                    end
                end
                S_ARMED: begin
                    if (sample_valid) begin
                        prev_d       = adc_data;
                        prev_valid_d = 1'b1;
                        tmo_cnt_d    = tmo_cnt_q + CNT_ONE;
                        if (edge_hit || auto_hit) begin
                            triggered_d  = 1'b1;
                            auto_fired_d = !edge_hit;
                            take_sample  = 1'b1;
                        end
                    end
                end
                S_CAPTURE: begin
                    take_sample = sample_valid;
                end
                default: state_d = S_IDLE;
            endcase
        end

        // Dropped samples still advance cap_cnt so the frame keeps its time base.
        if (take_sample) begin
            if (fifo_full) begin
                overflow_d = 1'b1;
            end else begin
                fifo_wr_d   = 1'b1;
                fifo_data_d = adc_data;
            end
            cap_cnt_d = cap_cnt_inc;
            state_d   = (cap_cnt_inc == post_len_q) ? S_DONE : S_CAPTURE;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q      <= S_IDLE;
            level_q      <= '0;
            falling_q    <= 1'b0;
            auto_q       <= 1'b0;
            timeout_q    <= '0;
            post_len_q   <= CNT_ONE;
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
            tmo_cnt_q    <= '0;
            cap_cnt_q    <= '0;
            triggered_q  <= 1'b0;
            auto_fired_q <= 1'b0;
            overflow_q   <= 1'b0;
            fifo_wr_q    <= 1'b0;
            fifo_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            level_q      <= level_d;
            falling_q    <= falling_d;
            auto_q       <= auto_d;
            timeout_q    <= timeout_d;
            post_len_q   <= post_len_d;
            prev_q       <= prev_d;
            prev_valid_q <= prev_valid_d;
            tmo_cnt_q    <= tmo_cnt_d;
            cap_cnt_q    <= cap_cnt_d;
            triggered_q  <= triggered_d;
            auto_fired_q <= auto_fired_d;
            overflow_q   <= overflow_d;
            fifo_wr_q    <= fifo_wr_d;
            fifo_data_q  <= fifo_data_d;
        end
    end

    assign fifo_wr    = fifo_wr_q;
    assign fifo_data  = fifo_data_q;
    assign busy       = (state_q == S_ARMED) || (state_q == S_CAPTURE);
    assign done       = (state_q == S_DONE);
    assign triggered  = triggered_q;
    assign auto_fired = auto_fired_q;
    assign overflow   = overflow_q;
    assign cap_cnt    = cap_cnt_q;

endmodule

// File: tb/tb_osc_trigger_capture.sv
// Directed bench for osc_trigger_capture: trigger modes, overflow, abort and reset cases.
module tb_osc_trigger_capture;

    logic        clk_in = 1'b0;
    logic        rst = 1'b1;
    logic        arm = 1'b0;
    logic        abort = 1'b0;
    logic        sample_valid = 1'b0;
    logic [7:0]  adc_data = '0;
    logic [7:0]  trig_level = '0;
    logic        trig_falling = 1'b0;
    logic        auto_en = 1'b0;
    logic [15:0] timeout = '0;
    logic [15:0] post_len = '0;
    logic        fifo_full = 1'b0;
    logic        fifo_wr;
    logic [7:0]  fifo_data;
    logic        busy, triggered, auto_fired, overflow, done;
    logic [15:0] cap_cnt;

    int compared = 0;
    int mismatched = 0;
    logic [7:0] wq[$];

    osc_trigger_capture #(.CNT_W(16)) dut (
        .clk_in(clk_in), .rst(rst), .arm(arm), .abort(abort),
        .sample_valid(sample_valid), .adc_data(adc_data),
        .trig_level(trig_level), .trig_falling(trig_falling),
        .auto_en(auto_en), .timeout(timeout), .post_len(post_len),
        .fifo_full(fifo_full), .fifo_wr(fifo_wr), .fifo_data(fifo_data),
        .busy(busy), .triggered(triggered), .auto_fired(auto_fired),
        .overflow(overflow), .done(done), .cap_cnt(cap_cnt)
    );

    always #5 clk_in = ~clk_in;

    // Record every FIFO write, sampled away from the rising edge.
    always @(negedge clk_in) begin
        if (fifo_wr) wq.push_back(fifo_data);
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_arm(input logic [7:0] lvl, input logic fall, input logic aen,
                          input logic [15:0] tmo, input logic [15:0] plen);
        trig_level = lvl; trig_falling = fall; auto_en = aen; timeout = tmo; post_len = plen;
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic samp(input logic [7:0] d, input logic full);
        sample_valid = 1'b1; adc_data = d; fifo_full = full;
        tick();
        sample_valid = 1'b0; fifo_full = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        compared++; if (fifo_wr !== 1'b0) begin mismatched++; $display("FAIL reset_fifo_wr got %b want 0", fifo_wr); end
        compared++; if (fifo_data !== 8'h00) begin mismatched++; $display("FAIL reset_fifo_data got %h want 00", fifo_data); end
        compared++; if ({busy, triggered, auto_fired, overflow, done} !== 5'b0) begin mismatched++; $display("FAIL reset_flags got %b want 00000", {busy, triggered, auto_fired, overflow, done}); end
        compared++; if (cap_cnt !== 16'd0) begin mismatched++; $display("FAIL reset_cap_cnt got %0d want 0", cap_cnt); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_rising();
        wq.delete();
        do_arm(8'h80, 1'b0, 1'b0, 16'd0, 16'd4);
        compared++; if (busy !== 1'b1) begin mismatched++; $display("FAIL rise_busy_after_arm got %b want 1", busy); end
        samp(8'h10, 0); samp(8'h70, 0);
        compared++; if (triggered !== 1'b0) begin mismatched++; $display("FAIL rise_no_trig got %b want 0", triggered); end
        samp(8'h90, 0);
        compared++; if (triggered !== 1'b1 || fifo_wr !== 1'b1 || fifo_data !== 8'h90) begin mismatched++; $display("FAIL rise_trig got trig=%b wr=%b data=%h want 1 1 90", triggered, fifo_wr, fifo_data); end
        samp(8'hA0, 0); samp(8'hB0, 0); samp(8'hC0, 0);
        compared++; if (done !== 1'b1 || busy !== 1'b0 || cap_cnt !== 16'd4) begin mismatched++; $display("FAIL rise_done got done=%b busy=%b cnt=%0d want 1 0 4", done, busy, cap_cnt); end
        samp(8'hD0, 0); tick();
        compared++; if (wq.size() !== 4 || wq[0] !== 8'h90 || wq[1] !== 8'hA0 || wq[2] !== 8'hB0 || wq[3] !== 8'hC0) begin mismatched++; $display("FAIL rise_writes got n=%0d %p want 90 a0 b0 c0", wq.size(), wq); end
        compared++; if (auto_fired !== 1'b0 || cap_cnt !== 16'd4) begin mismatched++; $display("FAIL rise_hold got af=%b cnt=%0d want 0 4", auto_fired, cap_cnt); end
    endtask

    task automatic test_falling();
        wq.delete();
        do_arm(8'h40, 1'b1, 1'b0, 16'd0, 16'd1);
        samp(8'h20, 0);
        compared++; if (triggered !== 1'b0 || busy !== 1'b1) begin mismatched++; $display("FAIL fall_first_sample got trig=%b busy=%b want 0 1", triggered, busy); end
        samp(8'h50, 0);
        compared++; if (triggered !== 1'b0) begin mismatched++; $display("FAIL fall_no_trig got %b want 0", triggered); end
        samp(8'h40, 0); tick();
        compared++; if (triggered !== 1'b1 || done !== 1'b1 || cap_cnt !== 16'd1) begin mismatched++; $display("FAIL fall_trig got trig=%b done=%b cnt=%0d want 1 1 1", triggered, done, cap_cnt); end
        compared++; if (wq.size() !== 1 || wq[0] !== 8'h40) begin mismatched++; $display("FAIL fall_writes got n=%0d %p want 40", wq.size(), wq); end
    endtask

    task automatic test_auto();
        wq.delete();
        do_arm(8'h80, 1'b0, 1'b1, 16'd5, 16'd2);
        for (int i = 0; i < 4; i++) samp(8'h33, 0);
        compared++; if (triggered !== 1'b0 || auto_fired !== 1'b0) begin mismatched++; $display("FAIL auto_early got trig=%b af=%b want 0 0", triggered, auto_fired); end
        samp(8'h33, 0);
        compared++; if (triggered !== 1'b1 || auto_fired !== 1'b1) begin mismatched++; $display("FAIL auto_fire got trig=%b af=%b want 1 1", triggered, auto_fired); end
        samp(8'h33, 0); tick();
        compared++; if (done !== 1'b1 || wq.size() !== 2 || wq[0] !== 8'h33 || wq[1] !== 8'h33) begin mismatched++; $display("FAIL auto_writes got done=%b n=%0d %p want 1 33 33", done, wq.size(), wq); end
    endtask

    task automatic test_overflow();
        wq.delete();
        do_arm(8'h80, 1'b0, 1'b0, 16'd0, 16'd4);
        compared++; if (auto_fired !== 1'b0) begin mismatched++; $display("FAIL ovf_arm_clears_auto got %b want 0", auto_fired); end
        samp(8'h10, 0); samp(8'h90, 0); samp(8'hA0, 1);
        compared++; if (fifo_wr !== 1'b0 || overflow !== 1'b1 || cap_cnt !== 16'd2) begin mismatched++; $display("FAIL ovf_drop got wr=%b ovf=%b cnt=%0d want 0 1 2", fifo_wr, overflow, cap_cnt); end
        samp(8'hB0, 0); samp(8'hC0, 0); tick();
        compared++; if (done !== 1'b1 || cap_cnt !== 16'd4 || overflow !== 1'b1) begin mismatched++; $display("FAIL ovf_done got done=%b cnt=%0d ovf=%b want 1 4 1", done, cap_cnt, overflow); end
        compared++; if (wq.size() !== 3 || wq[0] !== 8'h90 || wq[1] !== 8'hB0 || wq[2] !== 8'hC0) begin mismatched++; $display("FAIL ovf_writes got n=%0d %p want 90 b0 c0", wq.size(), wq); end
    endtask

    task automatic test_abort_arm();
        wq.delete();
        do_arm(8'h80, 1'b0, 1'b0, 16'd0, 16'd4);
        samp(8'h10, 0); samp(8'h90, 0); samp(8'hA0, 1);
        abort = 1'b1; arm = 1'b1; sample_valid = 1'b1; adc_data = 8'hB0;
        tick();
        abort = 1'b0; arm = 1'b0; sample_valid = 1'b0;
        compared++; if (busy !== 1'b0 || triggered !== 1'b0 || done !== 1'b0 || cap_cnt !== 16'd0 || fifo_wr !== 1'b0) begin mismatched++; $display("FAIL abort_state got busy=%b trig=%b done=%b cnt=%0d wr=%b want 0 0 0 0 0", busy, triggered, done, cap_cnt, fifo_wr); end
        compared++; if (overflow !== 1'b1) begin mismatched++; $display("FAIL abort_keeps_ovf got %b want 1", overflow); end
        samp(8'hC0, 0); tick();
        compared++; if (wq.size() !== 1 || wq[0] !== 8'h90 || busy !== 1'b0) begin mismatched++; $display("FAIL abort_no_writes got n=%0d %p busy=%b want 90 0", wq.size(), wq, busy); end
        do_arm(8'h80, 1'b0, 1'b0, 16'd0, 16'd4);
        compared++; if (overflow !== 1'b0 || busy !== 1'b1) begin mismatched++; $display("FAIL rearm_clears_ovf got ovf=%b busy=%b want 0 1", overflow, busy); end
        abort = 1'b1; tick(); abort = 1'b0;
    endtask

    task automatic test_reset_mid();
        wq.delete();
        do_arm(8'h80, 1'b0, 1'b0, 16'd0, 16'd4);
        samp(8'h10, 0); samp(8'h90, 0);
        rst = 1'b1; sample_valid = 1'b1; adc_data = 8'hA0;
        tick();
        rst = 1'b0; sample_valid = 1'b0;
        compared++; if (fifo_wr !== 1'b0 || fifo_data !== 8'h00 || cap_cnt !== 16'd0) begin mismatched++; $display("FAIL rst_mid_data got wr=%b data=%h cnt=%0d want 0 00 0", fifo_wr, fifo_data, cap_cnt); end
        compared++; if ({busy, triggered, auto_fired, overflow, done} !== 5'b0) begin mismatched++; $display("FAIL rst_mid_flags got %b want 00000", {busy, triggered, auto_fired, overflow, done}); end
        tick();
        compared++; if (wq.size() !== 1 || wq[0] !== 8'h90) begin mismatched++; $display("FAIL rst_mid_writes got n=%0d %p want 90", wq.size(), wq); end
        wq.delete();
        do_arm(8'h80, 1'b0, 1'b0, 16'd0, 16'd0);
        samp(8'h10, 0); samp(8'h90, 0); samp(8'hA0, 0); tick();
        compared++; if (done !== 1'b1 || cap_cnt !== 16'd1 || wq.size() !== 1 || wq[0] !== 8'h90) begin mismatched++; $display("FAIL plen0 got done=%b cnt=%0d n=%0d %p want 1 1 90", done, cap_cnt, wq.size(), wq); end
    endtask

    initial begin
        test_reset();
        test_rising();
        test_falling();
        test_auto();
        test_overflow();
        test_abort_arm();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/osc_trigger_capture.md
# osc_trigger_capture

Trigger and capture controller between the 8-bit ADC sample stream and the single-clock sample FIFO. It watches incoming samples for a level crossing on the selected edge, or forces a trigger after a programmable timeout in auto mode. It then writes exactly the requested number of post-trigger samples into the FIFO via its write-enable/data pins. It reports status so the readout side knows when a complete frame is available.

## Interface
- CNT_W, 16: width of the capture-length, counter and timeout registers.
- clk_in  input  1  single clock for all logic. One clock; reset is synchronous and active-high.
- rst  input  1  synchronous active-high reset, sampled on rising clk_in.
- arm  input  1  single-cycle request to start a capture; honoured only in IDLE or DONE.
- abort  input  1  return to IDLE from any state on the next edge.
- sample_valid  input  1  adc_data is a new sample this cycle.
- adc_data  input  8  unsigned ADC sample.
- trig_level  input  8  trigger threshold; latched at arm.
- trig_falling  input  1  0 = rising edge, 1 = falling edge; latched at arm.
- auto_en  input  1  enables the timeout trigger; latched at arm.
- timeout  input  CNT_W  valid samples to wait before the auto trigger; latched at arm.
- post_len  input  CNT_W  samples to capture, including the trigger sample; latched at arm; 0 is treated as 1.
- fifo_full  input  1  FIFO cannot accept a write this cycle.
- fifo_wr  output  1  FIFO write enable; registered.
- fifo_data  output  8  sample written when fifo_wr is high; registered.
- busy  output  1  high in ARMED or CAPTURE.
- triggered  output  1  high from the trigger until leaving CAPTURE/DONE.
- auto_fired  output  1  sticky: the current frame was started by the timeout.
- overflow  output  1  sticky: at least one capture sample was dropped because fifo_full was high.
- done  output  1  high in DONE.
- cap_cnt  output  CNT_W  samples consumed in the current capture.

## Operation
- States: IDLE, ARMED, CAPTURE, DONE.
- IDLE or DONE + arm:
  - Latch the configuration.
  - Clear cap_cnt, the timeout counter, prev_valid, triggered, auto_fired and overflow.
  - Go to ARMED.
- ARMED:
  - On each valid sample, set prev <= adc_data and prev_valid <= 1.
  - Rising trigger: prev_valid && prev < level && adc_data >= level.
  - Falling trigger: prev_valid && prev > level && adc_data <= level.
  - The first valid sample after arm never triggers.
  - Timeout counter increments per valid sample. If auto_en and the counter equals timeout-1 on a valid sample that is not an edge trigger, that sample is the forced trigger and auto_fired is set. With auto_en and timeout 0, the first valid sample triggers.
  - On a trigger sample: set triggered, go to CAPTURE. The trigger sample is capture sample 0 and is handled exactly like a CAPTURE sample.
- CAPTURE, on each valid sample:
  - If fifo_full is low, write the sample.
  - If fifo_full is high, drop the sample and set overflow. The sample still counts, which keeps time base integrity.
  - cap_cnt increments. When it reaches the effective post_len, go to DONE.
- DONE: holds all flags and cap_cnt until arm or abort.
- abort (any state) and rst both do the following; abort has priority over arm and over a trigger in the same cycle:
  - State to IDLE.
  - fifo_wr 0, busy 0, triggered 0, done 0.
  - cap_cnt 0, counters 0, prev_valid 0.
  - Sticky flags: abort keeps them; rst clears them.
- arm in ARMED or CAPTURE is ignored.
- sample_valid low: no state, counter or write activity, except arm/abort.
- Counter arithmetic is unsigned CNT_W-bit. cap_cnt never wraps because capture ends at post_len ≤ 2^CNT_W-1.

## Timing
- Reset values: fifo_wr 0, fifo_data 0x00, busy 0, triggered 0, auto_fired 0, overflow 0, done 0, cap_cnt 0; state IDLE.
- arm sampled at edge N: busy=1 after edge N. The sample at edge N+1 is the first one evaluated.
- A write sample presented with sample_valid at edge N gives fifo_wr=1 and fifo_data=sample for the cycle after edge N (1-cycle latency). fifo_wr is never high for two consecutive cycles unless sample_valid was.
- fifo_full is evaluated in the same cycle as sample_valid. It is not evaluated in the output cycle.
- Last capture sample at edge N: fifo_wr pulses after N (if not full). done=1 and busy=0 also after N.
- triggered and the CAPTURE state both become visible after the trigger-sample edge.

## Test plan
- Rising trigger: level 0x80, post_len 4, samples 0x10,0x70,0x90,0xA0,0xB0,0xC0,0xD0 -> trigger on 0x90; writes 0x90,0xA0,0xB0,0xC0; done=1, cap_cnt=4, auto_fired=0.
- Falling edge, first-sample rule: falling, level 0x40, first post-arm sample 0x20, then 0x50,0x40 -> no trigger on 0x20; trigger on 0x40.
- Auto trigger: auto_en=1, timeout 5, constant 0x33, post_len 2 -> 5th sample forces trigger; writes 0x33,0x33; auto_fired=1.
- Overflow: post_len 4, fifo_full high during the 2nd capture sample -> 3 writes, cap_cnt=4, done=1, overflow=1.
- Abort/arm collision: abort and arm together in CAPTURE -> IDLE next cycle, no further fifo_wr, overflow preserved; a later arm clears it.
- Reset mid-capture: rst during CAPTURE with sample_valid high -> all outputs at reset values next cycle, no write for that sample; post_len 0 capture afterwards writes exactly 1 sample.
